// File: rtl/jackpot_n.sv
// rtl/jackpot_n.sv - parametrised reaction game: stepping LED, switch match, speed levels, score
module jackpot_n #(
    parameter int N_LEDS   = 4,
    parameter int CLK_DIV  = 50000000,
    parameter int LEVELS   = 4,
    parameter int WIN_HOLD = 3,
    parameter int SCORE_W  = 8,
    localparam int LW      = (LEVELS > 1) ? $clog2(LEVELS) : 1
) (
    input  logic               CLOCK,
    input  logic               RESET,
    input  logic [N_LEDS-1:0]  SWITCHES,
    input  logic               MODE,
    output logic [N_LEDS-1:0]  LEDS,
    output logic [LW-1:0]      LEVEL,
    output logic [SCORE_W-1:0] SCORE,
    output logic               WIN
);

    localparam int CW = $clog2(CLK_DIV);
    localparam int HW = (WIN_HOLD > 1) ? $clog2(WIN_HOLD) : 1;
    localparam logic [N_LEDS-1:0] LED0 = N_LEDS'(1);
    localparam logic [N_LEDS-1:0] ALL_ON = '1;

    typedef enum logic {ST_RUN, ST_WIN_SHOW} state_t;

    state_t             state_q, state_d;
    logic [N_LEDS-1:0]  leds_q, leds_d;
    logic               dir_q, dir_d;
    logic [LW-1:0]      level_q, level_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic               win_q, win_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [HW-1:0]      hold_q, hold_d;
    logic [N_LEDS-1:0]  pending_q, pending_d;
    logic [N_LEDS-1:0]  sync1_q, sync1_d;
    logic [N_LEDS-1:0]  sync2_q, sync2_d;
    logic [N_LEDS-1:0]  prev_q, prev_d;
    logic [1:0]         arm_q, arm_d;

    logic [CW-1:0]      term_cnt;
    logic               tick;
    logic [N_LEDS-1:0]  edges;
    logic [N_LEDS-1:0]  hits;
    logic               onehot;
    logic [N_LEDS-1:0]  adv_leds;
    logic               adv_dir;

    // Prescaler terminal count, qualified switch edges and the next LED position
    always_comb begin
        term_cnt = CW'((CLK_DIV >> level_q) - 1);
        tick     = (cnt_q == term_cnt);
        // A switch already high or rising as reset releases is treated as a
        // pre-existing level, not a press, until the synchroniser has refilled.
        edges    = sync2_q & ~prev_q & {N_LEDS{arm_q == 2'd3}};
        hits     = pending_q | edges;
        onehot   = (leds_q != '0) && ((leds_q & (leds_q - LED0)) == '0);
        adv_leds = LED0;
        adv_dir  = 1'b1;
        if (!onehot) begin
            adv_leds = LED0;
            adv_dir  = 1'b1;
        end else if (!MODE) begin
            adv_leds = {leds_q[N_LEDS-2:0], leds_q[N_LEDS-1]};
            adv_dir  = 1'b1;
        end else if (dir_q) begin
            adv_leds = leds_q[N_LEDS-1] ? (leds_q >> 1) : (leds_q << 1);
            adv_dir  = ~leds_q[N_LEDS-1];
        end else begin
            adv_leds = leds_q[0] ? (leds_q << 1) : (leds_q >> 1);
            adv_dir  = leds_q[0];
        end
    end

    // Game FSM: RUN evaluates the pending presses each tick, WIN_SHOW holds the all-on pattern
    always_comb begin
        state_d   = state_q;
        leds_d    = leds_q;
        dir_d     = dir_q;
        level_d   = level_q;
        score_d   = score_q;
        win_d     = 1'b0;
        hold_d    = hold_q;
        pending_d = pending_q;
        sync1_d   = SWITCHES;
        sync2_d   = sync1_q;
        prev_d    = sync2_q;
        arm_d     = (arm_q == 2'd3) ? arm_q : arm_q + 2'd1;
        // The wrap on tick also zeroes the count on WIN_SHOW entry and exit.
        cnt_d     = tick ? '0 : cnt_q + 1'b1;
        case (state_q)
            ST_RUN: begin
                pending_d = hits;
                if (tick) begin
                    pending_d = '0;
                    if (onehot && hits == leds_q) begin
                        state_d = ST_WIN_SHOW;
                        leds_d  = ALL_ON;
                        win_d   = 1'b1;
                        score_d = (&score_q) ? score_q : score_q + 1'b1;
                        level_d = (level_q == LW'(LEVELS - 1)) ? level_q : level_q + 1'b1;
                        hold_d  = '0;
                    end else begin
                        if (hits != '0) begin
                            level_d = '0;
                        end
                        leds_d = adv_leds;
                        dir_d  = adv_dir;
                    end
                end
            end
            ST_WIN_SHOW: begin
                pending_d = '0;
                if (tick) begin
                    if (hold_q == HW'(WIN_HOLD - 1)) begin
                        state_d = ST_RUN;
                        leds_d  = LED0;
                        dir_d   = 1'b1;
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_RUN;
                leds_d  = LED0;
                dir_d   = 1'b1;
            end
        endcase
    end

    // State registers with asynchronous reset to the start-of-game position
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= ST_RUN;
            leds_q    <= LED0;
            dir_q     <= 1'b1;
            level_q   <= '0;
            score_q   <= '0;
            win_q     <= 1'b0;
            cnt_q     <= '0;
            hold_q    <= '0;
            pending_q <= '0;
            sync1_q   <= '0;
            sync2_q   <= '0;
            prev_q    <= '0;
            arm_q     <= '0;
        end else begin
            state_q   <= state_d;
            leds_q    <= leds_d;
            dir_q     <= dir_d;
            level_q   <= level_d;
            score_q   <= score_d;
            win_q     <= win_d;
            cnt_q     <= cnt_d;
            hold_q    <= hold_d;
            pending_q <= pending_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            prev_q    <= prev_d;
            arm_q     <= arm_d;
        end
    end

    assign LEDS  = leds_q;
    assign LEVEL = level_q;
    assign SCORE = score_q;
    assign WIN   = win_q;

endmodule

// File: tb/tb_jackpot_n.sv
// tb/tb_jackpot_n.sv - scoreboard bench for jackpot_n (4 LEDs, CLK_DIV 8, 4 levels, 2-bit score)
module tb_jackpot_n;

    logic       CLOCK = 1'b0;
    logic       RESET = 1'b0;
    logic       MODE  = 1'b0;
    logic [3:0] SWITCHES = 4'b0000;
    logic [3:0] LEDS;
    logic [1:0] LEVEL;
    logic [1:0] SCORE;
    logic       WIN;

    jackpot_n #(.N_LEDS(4), .CLK_DIV(8), .LEVELS(4), .WIN_HOLD(3), .SCORE_W(2)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .SWITCHES(SWITCHES), .MODE(MODE),
        .LEDS(LEDS), .LEVEL(LEVEL), .SCORE(SCORE), .WIN(WIN)
    );

    always #5 CLOCK = ~CLOCK;

    typedef struct packed {
        logic [3:0]  leds;
        logic [1:0]  level;
        logic [1:0]  score;
        logic        win;
        logic [15:0] gap;
    } ev_t;

    ev_t        exp_q[$];
    int         vectors = 0;
    int         miscompares = 0;
    bit         mon_en = 1'b0;
    int         cyc = 0;
    int         last_evt = 0;
    logic [3:0] last_leds = 4'b0001;
    ev_t        obs_ev;
    ev_t        exp_ev;

    // Every LED change is an event popped from the scoreboard; WIN must be low otherwise
    always @(negedge CLOCK) begin
        if (!RESET) begin
            cyc = 0;
            last_evt = 0;
            last_leds = LEDS;
        end else if (mon_en) begin
            cyc++;
            vectors++;
            if (LEDS !== last_leds) begin
                obs_ev = '{leds: LEDS, level: LEVEL, score: SCORE, win: WIN, gap: 16'(cyc - last_evt)};
                assert (exp_q.size() != 0) else begin
                    miscompares++;
                    $error("FAIL unexpected_event leds=%b level=%0d score=%0d at cycle %0d, expected no event", LEDS, LEVEL, SCORE, cyc);
                end
                if (exp_q.size() != 0) begin
                    exp_ev = exp_q.pop_front();
                    assert (obs_ev === exp_ev) else begin
                        miscompares++;
                        $error("FAIL event got leds=%b lvl=%0d score=%0d win=%b gap=%0d, want leds=%b lvl=%0d score=%0d win=%b gap=%0d",
                               obs_ev.leds, obs_ev.level, obs_ev.score, obs_ev.win, obs_ev.gap,
                               exp_ev.leds, exp_ev.level, exp_ev.score, exp_ev.win, exp_ev.gap);
                    end
                end
                last_evt = cyc;
                last_leds = LEDS;
            end else begin
                assert (WIN === 1'b0) else begin
                    miscompares++;
                    $error("FAIL win_pulse got WIN=%b at cycle %0d with no LED change, want 0", WIN, cyc);
                end
            end
        end else begin
            last_leds = LEDS;
        end
    end

    task automatic push(input logic [3:0] l, input logic [1:0] lv, input logic [1:0] s, input logic w, input int g);
        exp_q.push_back('{leds: l, level: lv, score: s, win: w, gap: 16'(g)});
    endtask

    task automatic check_reset(input string tag);
        vectors++;
        assert ({LEDS, LEVEL, SCORE, WIN} === {4'b0001, 2'd0, 2'd0, 1'b0}) else begin
            miscompares++;
            $error("FAIL %s got leds=%b lvl=%0d score=%0d win=%b, want leds=0001 lvl=0 score=0 win=0", tag, LEDS, LEVEL, SCORE, WIN);
        end
    endtask

    task automatic check_drained(input string tag);
        vectors++;
        assert (exp_q.size() == 0) else begin
            miscompares++;
            $error("FAIL %s got %0d events outstanding, want 0", tag, exp_q.size());
        end
    endtask

    task automatic wait_leds(input logic [3:0] p);
        int n = 0;
        while (LEDS === p && n < 500) begin @(negedge CLOCK); n++; end
        while (LEDS !== p && n < 500) begin @(negedge CLOCK); n++; end
        vectors++;
        assert (n < 500) else begin
            miscompares++;
            $error("FAIL wait_leds timeout got leds=%b, want %b", LEDS, p);
        end
    endtask

    task automatic wait_qsize(input int k);
        int n = 0;
        @(posedge CLOCK);
        while (exp_q.size() > k && n < 2000) begin @(posedge CLOCK); n++; end
        vectors++;
        assert (n < 2000) else begin
            miscompares++;
            $error("FAIL wait_queue timeout got %0d pending, want %0d", exp_q.size(), k);
        end
    endtask

    task automatic pulse(input logic [3:0] m);
        SWITCHES = m;
        @(negedge CLOCK);
        SWITCHES = 4'b0000;
    endtask

    task automatic release_rst(input logic [3:0] sw);
        @(negedge CLOCK);
        #2;
        RESET = 1'b1;
        SWITCHES = sw;
        @(negedge CLOCK);
        SWITCHES = 4'b0000;
    endtask

    task automatic assert_rst(input string tag);
        mon_en = 1'b0;
        @(negedge CLOCK);
        #2;
        RESET = 1'b0;
        #1;
        check_reset(tag);
    endtask

    initial begin
        repeat (3) @(negedge CLOCK);
        check_reset("reset_initial");
        mon_en = 1'b1;
        // Plain rotation at level 0
        push(4'b0010, 0, 0, 0, 8); push(4'b0100, 0, 0, 0, 8);
        push(4'b1000, 0, 0, 0, 8); push(4'b0001, 0, 0, 0, 8);
        release_rst(4'b0000);
        wait_qsize(0);

        // Win on LED 2, hold three level-1 ticks, then resume from bit 0
        push(4'b0010, 0, 0, 0, 8); push(4'b0100, 0, 0, 0, 8);
        push(4'b1111, 1, 1, 1, 8); push(4'b0001, 1, 1, 0, 12);
        push(4'b0010, 1, 1, 0, 4); push(4'b0100, 1, 1, 0, 4);
        wait_leds(4'b0100);
        pulse(4'b0100);
        wait_qsize(0);

        // Press landing on the tick edge still wins; then a wrong switch at level 2
        push(4'b1111, 2, 2, 1, 4); push(4'b0001, 2, 2, 0, 6);
        push(4'b0010, 2, 2, 0, 2); push(4'b0100, 2, 2, 0, 2);
        push(4'b1000, 0, 2, 0, 2); push(4'b0001, 0, 2, 0, 8);
        @(negedge CLOCK);
        pulse(4'b0100);
        wait_leds(4'b0010);
        pulse(4'b0001);
        wait_qsize(0);

        // Right switch plus an extra one is a miss
        push(4'b0010, 0, 2, 0, 8); push(4'b0100, 0, 2, 0, 8);
        push(4'b1000, 0, 2, 0, 8); push(4'b0001, 0, 2, 0, 8);
        wait_leds(4'b0100);
        pulse(4'b0101);
        wait_qsize(0);

        // Bounce both ends, then switch to rotate while descending
        @(negedge CLOCK);
        MODE = 1'b1;
        push(4'b0010, 0, 2, 0, 8); push(4'b0100, 0, 2, 0, 8); push(4'b1000, 0, 2, 0, 8);
        push(4'b0100, 0, 2, 0, 8); push(4'b0010, 0, 2, 0, 8); push(4'b0001, 0, 2, 0, 8);
        push(4'b0010, 0, 2, 0, 8); push(4'b0100, 0, 2, 0, 8); push(4'b1000, 0, 2, 0, 8);
        push(4'b0100, 0, 2, 0, 8); push(4'b1000, 0, 2, 0, 8); push(4'b0001, 0, 2, 0, 8);
        wait_qsize(2);
        @(negedge CLOCK);
        MODE = 1'b0;
        wait_qsize(0);

        // Four wins: score saturates at 3, level saturates at 3 (one-cycle steps)
        push(4'b0010, 0, 2, 0, 8);  push(4'b0100, 0, 2, 0, 8);
        push(4'b1111, 1, 3, 1, 8);  push(4'b0001, 1, 3, 0, 12);
        push(4'b0010, 1, 3, 0, 4);  push(4'b0100, 1, 3, 0, 4);
        push(4'b1111, 2, 3, 1, 4);  push(4'b0001, 2, 3, 0, 6);
        push(4'b0010, 2, 3, 0, 2);  push(4'b0100, 2, 3, 0, 2);
        push(4'b1111, 3, 3, 1, 2);  push(4'b0001, 3, 3, 0, 3);
        push(4'b0010, 3, 3, 0, 1);  push(4'b0100, 3, 3, 0, 1);
        push(4'b1111, 3, 3, 1, 1);  push(4'b0001, 3, 3, 0, 3);
        wait_leds(4'b0100);
        pulse(4'b0100);
        wait_leds(4'b0100);
        pulse(4'b0100);
        wait_leds(4'b0010);
        pulse(4'b0100);
        wait_leds(4'b0001);
        pulse(4'b0100);
        wait_qsize(0);

        // Reset at full speed; a switch rising at release must not count
        assert_rst("reset_fast_run");
        mon_en = 1'b1;
        push(4'b0010, 0, 0, 0, 8); push(4'b0100, 0, 0, 0, 8);
        release_rst(4'b0001);
        wait_leds(4'b0100);
        repeat (3) @(negedge CLOCK);
        check_drained("drained_before_mid_step_reset");
        assert_rst("reset_mid_step");

        // Reset in the middle of the win display
        mon_en = 1'b1;
        push(4'b0010, 0, 0, 0, 8); push(4'b0100, 0, 0, 0, 8); push(4'b1111, 1, 1, 1, 8);
        release_rst(4'b0000);
        wait_leds(4'b0100);
        pulse(4'b0100);
        wait_leds(4'b1111);
        repeat (2) @(negedge CLOCK);
        check_drained("drained_before_win_reset");
        assert_rst("reset_mid_win_show");

        mon_en = 1'b1;
        push(4'b0010, 0, 0, 0, 8);
        release_rst(4'b0000);
        wait_qsize(0);
        check_drained("drained_at_end");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
